// File: rtl/aes_encryption_mux.sv
// aes_encryption_mux
// ------------------
// Routes one of four AES round-stage results onto the shared process data bus
// that feeds the encryption state register. Two views of the selected word are
// provided: a purely combinational one for same-cycle forwarding, and a
// registered copy that is loaded only on request and flagged once loaded.
//
// Ports:
//   clk              system clock, rising-edge active
//   rst              asynchronous reset, active-high
//   process_output   stage select: 00 ark, 01 sb, 10 mc, 11 sr
//   ark_out          AddRoundKey result
//   sb_out           SubBytes result
//   mc_out           MixColumns result
//   sr_out           ShiftRows result
//   capture_en       load the currently selected word into the output register
//   process_out_data combinational selected word
//   process_out_q    registered selected word
//   out_valid        process_out_q holds a word captured since reset (sticky)
//   sel_q            select code used at the last capture

module aes_encryption_mux #(
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        process_output,
   input  logic [DATA_W-1:0] ark_out,
   input  logic [DATA_W-1:0] sb_out,
   input  logic [DATA_W-1:0] mc_out,
   input  logic [DATA_W-1:0] sr_out,
   input  logic              capture_en,
   output logic [DATA_W-1:0] process_out_data,
   output logic [DATA_W-1:0] process_out_q,
   output logic              out_valid,
   output logic [1:0]        sel_q
);

   // Combinational stage select. The encoding is fixed by the controller and
   // deliberately does not follow AES round order. The default assignment
   // keeps the block latch-free even though all four codes are covered.
   always_comb begin
      process_out_data = ark_out;
      case (process_output)
         2'b00:   process_out_data = ark_out;
         2'b01:   process_out_data = sb_out;
         2'b10:   process_out_data = mc_out;
         2'b11:   process_out_data = sr_out;
         default: process_out_data = ark_out;
      endcase
   end

   // Capture register. Reset clears everything immediately and takes priority
   // over capture_en. Without capture_en all registered outputs hold, and
   // out_valid stays set until the next reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         process_out_q <= '0;
         sel_q         <= 2'b00;
         out_valid     <= 1'b0;
      end else if (capture_en) begin
         process_out_q <= process_out_data;
         sel_q         <= process_output;
         out_valid     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_encryption_mux.sv
module tb_aes_encryption_mux;

   localparam int DATA_W = 128;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [1:0]        sel;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              clk_run;
   logic [1:0]        process_output;
   logic [DATA_W-1:0] ark_out;
   logic [DATA_W-1:0] sb_out;
   logic [DATA_W-1:0] mc_out;
   logic [DATA_W-1:0] sr_out;
   logic              capture_en;
   logic [DATA_W-1:0] process_out_data;
   logic [DATA_W-1:0] process_out_q;
   logic              out_valid;
   logic [1:0]        sel_q;

   exp_t sb_q[$];
   exp_t last_exp;
   int   errors;
   int   checks;

   aes_encryption_mux #(.DATA_W(DATA_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .process_output   (process_output),
      .ark_out          (ark_out),
      .sb_out           (sb_out),
      .mc_out           (mc_out),
      .sr_out           (sr_out),
      .capture_en       (capture_en),
      .process_out_data (process_out_data),
      .process_out_q    (process_out_q),
      .out_valid        (out_valid),
      .sel_q            (sel_q)
   );

   // Gated free-running clock so the combinational tests can run with it stopped.
   initial clk = 1'b0;
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   // Reference model of the select encoding.
   function automatic logic [DATA_W-1:0] model_mux(input logic [1:0] s,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] c,
                                                   input logic [DATA_W-1:0] d);
      case (s)
         2'b00:   return a;
         2'b01:   return b;
         2'b10:   return c;
         default: return d;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic applyStimulus(input logic [1:0] s, input logic cap);
      process_output = s;
      ark_out        = rand_word();
      sb_out         = rand_word();
      mc_out         = rand_word();
      sr_out         = rand_word();
      capture_en     = cap;
   endtask

   task automatic push_expected();
      exp_t e;
      e.data = model_mux(process_output, ark_out, sb_out, mc_out, sr_out);
      e.sel  = process_output;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (process_out_q !== '0) begin
         errors++;
         $display("[TB] FAIL reset_q: got %h expected 0", process_out_q);
      end
      checks++;
      if (sel_q !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_sel: got %b expected 00", sel_q);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_comb_select();
      logic [DATA_W-1:0] exp_tab [4];
      exp_tab[0] = 128'h11;
      exp_tab[1] = 128'h22;
      exp_tab[2] = 128'h33;
      exp_tab[3] = 128'h44;
      ark_out = 128'h11;
      sb_out  = 128'h22;
      mc_out  = 128'h33;
      sr_out  = 128'h44;
      for (int i = 0; i < 4; i++) begin
         process_output = 2'(i);
         #1;
         checks++;
         if (process_out_data !== exp_tab[i]) begin
            errors++;
            $display("[TB] FAIL comb_sel%0d: got %h expected %h", i, process_out_data, exp_tab[i]);
         end
      end
   endtask

   task automatic test_comb_track();
      logic [DATA_W-1:0] pat;
      pat = 128'h0123456789ABCDEF0123456789ABCDEF;
      ark_out = '1;
      sb_out = '0;
      mc_out = '0;
      sr_out = '0;
      process_output = 2'b00;
      #1;
      checks++;
      if (process_out_data !== {DATA_W{1'b1}}) begin
         errors++;
         $display("[TB] FAIL track_ones: got %h expected all ones", process_out_data);
      end
      ark_out = pat;
      #1;
      checks++;
      if (process_out_data !== pat) begin
         errors++;
         $display("[TB] FAIL track_pattern: got %h expected %h", process_out_data, pat);
      end
      sb_out = rand_word();
      mc_out = rand_word();
      sr_out = '1;
      #1;
      checks++;
      if (process_out_data !== pat) begin
         errors++;
         $display("[TB] FAIL track_isolation: got %h expected %h", process_out_data, pat);
      end
   endtask

   task automatic test_capture();
      exp_t e;
      @(negedge clk);
      applyStimulus(2'b10, 1'b1);
      mc_out = 128'h33;
      push_expected();
      @(posedge clk);
      #1;
      capture_en = 1'b0;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL capture_queue: got empty expected entry");
      end else begin
         e = sb_q.pop_front();
         last_exp = e;
         checks++;
         if (process_out_q !== e.data) begin
            errors++;
            $display("[TB] FAIL capture_q: got %h expected %h", process_out_q, e.data);
         end
         checks++;
         if (sel_q !== e.sel) begin
            errors++;
            $display("[TB] FAIL capture_sel: got %b expected %b", sel_q, e.sel);
         end
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL capture_valid: got %b expected 1", out_valid);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         applyStimulus(2'($urandom_range(0, 3)), 1'b0);
         @(posedge clk);
         #1;
         checks++;
         if (process_out_q !== last_exp.data || sel_q !== last_exp.sel || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_cycle%0d: got q=%h sel=%b v=%b expected q=%h sel=%b v=1",
                     i, process_out_q, sel_q, out_valid, last_exp.data, last_exp.sel);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [DATA_W-1:0] comb_exp;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         applyStimulus(2'(i % 4), 1'b1);
         push_expected();
         #1;
         comb_exp = model_mux(process_output, ark_out, sb_out, mc_out, sr_out);
         checks++;
         if (process_out_data !== comb_exp) begin
            errors++;
            $display("[TB] FAIL b2b_comb%0d: got %h expected %h", i, process_out_data, comb_exp);
         end
         @(posedge clk);
         #1;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL b2b_queue%0d: got empty expected entry", i);
         end else begin
            e = sb_q.pop_front();
            last_exp = e;
            if (process_out_q !== e.data || sel_q !== e.sel || out_valid !== 1'b1) begin
               errors++;
               $display("[TB] FAIL b2b_cap%0d: got q=%h sel=%b v=%b expected q=%h sel=%b v=1",
                        i, process_out_q, sel_q, out_valid, e.data, e.sel);
            end
         end
      end
      @(negedge clk);
      capture_en = 1'b0;
   endtask

   task automatic test_async_reset_midop();
      logic [DATA_W-1:0] comb_exp;
      @(negedge clk);
      applyStimulus(2'b01, 1'b0);
      #2;
      rst = 1'b1;
      sb_q.delete();
      #1;
      checks++;
      if (process_out_q !== '0 || sel_q !== 2'b00 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got q=%h sel=%b v=%b expected 0/00/0",
                  process_out_q, sel_q, out_valid);
      end
      comb_exp = model_mux(process_output, ark_out, sb_out, mc_out, sr_out);
      checks++;
      if (process_out_data !== comb_exp) begin
         errors++;
         $display("[TB] FAIL reset_comb: got %h expected %h", process_out_data, comb_exp);
      end
      process_output = 2'b11;
      #1;
      checks++;
      if (process_out_data !== sr_out) begin
         errors++;
         $display("[TB] FAIL reset_comb_follow: got %h expected %h", process_out_data, sr_out);
      end
   endtask

   task automatic test_reset_wins();
      exp_t e;
      @(negedge clk);
      applyStimulus(2'b10, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (process_out_q !== '0 || sel_q !== 2'b00 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_wins: got q=%h sel=%b v=%b expected 0/00/0",
                  process_out_q, sel_q, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(2'b11, 1'b1);
      push_expected();
      @(posedge clk);
      #1;
      capture_en = 1'b0;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL release_queue: got empty expected entry");
      end else begin
         e = sb_q.pop_front();
         if (process_out_q !== e.data || sel_q !== e.sel || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_cap: got q=%h sel=%b v=%b expected q=%h sel=%b v=1",
                     process_out_q, sel_q, out_valid, e.data, e.sel);
         end
      end
   endtask

   task automatic checkOutput();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
      end
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      clk_run        = 1'b0;
      rst            = 1'b0;
      capture_en     = 1'b0;
      process_output = 2'b00;
      ark_out        = '0;
      sb_out         = '0;
      mc_out         = '0;
      sr_out         = '0;
      last_exp       = '0;

      test_reset();
      test_comb_select();
      test_comb_track();

      clk_run = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      test_capture();
      test_hold();
      test_back_to_back();
      test_async_reset_midop();
      test_reset_wins();
      checkOutput();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
